spram_arbiter: RTL
==================

Name: spram_arbiter

Overview:
Shares one single-port RAM (write-enable, address, write-data and read-data ports) between NUM_REQ requesters. Each requester has a valid/ready request channel and a read-response channel.
- Arbitration is round-robin.
- A lock option holds the grant for back-to-back bursts.
- The block sits between client engines and the RAM and owns every RAM control pin.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 4, RAM address width
DATA_W, 8, RAM data width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_we  input  NUM_REQ  1 = write, 0 = read
req_lock  input  NUM_REQ  keep grant after this beat
req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  input  NUM_REQ*DATA_W  packed write data
req_ready  output  NUM_REQ  one-hot accept, combinational
rsp_valid  output  NUM_REQ  read-data valid pulse, registered
rsp_data  output  DATA_W  read data, shared bus
ram_we  output  1  to RAM write enable
ram_addr  output  ADDR_W  to RAM address
ram_din  output  DATA_W  to RAM write data
ram_dout  input  DATA_W  from RAM, synchronous read (valid the cycle after address sampled)
busy  output  1  high while a grant is held (ST_LOCK)

Behaviour:
- Reset (async on rst_n low, released synchronously by design convention):
  - rr_ptr = 0, state = ST_IDLE, rsp_valid = 0, busy = 0.
  - ram_we = 0, ram_addr = 0, ram_din = 0, rsp_data = 0.
- States:
  - ST_IDLE: no lock held.
  - ST_LOCK: grant pinned to lock_id.
- Grant selection (combinational):
  - ST_IDLE: first requester with req_valid set, scanning from rr_ptr upward modulo NUM_REQ.
  - ST_LOCK: lock_id only, regardless of other valids.
- Accept: req_ready[g] = req_valid[g] for the granted g; all other bits 0. A beat is accepted when valid && ready.
- RAM drive:
  - On acceptance: ram_we = req_we[g], ram_addr and ram_din from slice g, combinational.
  - No acceptance: ram_we = 0; addr and din hold their last accepted values.
  - The RAM never sees a write without an accepted beat.
- Read latency:
  - Accepted read at edge N: rsp_valid[g] = 1 and rsp_data = ram_dout during cycle N+1, for one cycle only.
  - Writes produce no response.
- rr_ptr update: on each acceptance in ST_IDLE with req_lock[g] = 0, rr_ptr = (g+1) mod NUM_REQ.
- Transitions:
  - ST_IDLE -> ST_LOCK: accepted beat with req_lock[g] = 1; lock_id = g.
  - ST_LOCK -> ST_LOCK: requester lock_id accepts a beat with req_lock = 1.
  - ST_LOCK -> ST_IDLE: requester lock_id accepts a beat with req_lock = 0; rr_ptr = lock_id+1.
  - ST_LOCK with req_valid[lock_id] = 0: stay locked, ready = 0, others starve (intended).
- Simultaneous requests: exactly one accepted per cycle; the others see ready = 0 and must hold their request stable.
- Reset mid-operation: a pending rsp_valid is dropped; lock and pointer are cleared.

Optional Feature:
SPRAM_ARB_FIXED_PRIO_EN
- Defined: rr_ptr is removed; in ST_IDLE the lowest-index valid requester always wins. Lock behaviour is unchanged.
- Undefined: round-robin as above.

Decomposition:
- Package spram_arb_pkg holds:
  - state enum (ST_IDLE, ST_LOCK);
  - localparam IDX_W = $clog2(NUM_REQ) helper function;
  - default width constants.
- Sub-module rr_pick: combinational, inputs req vector and start pointer, outputs one-hot grant plus index. Reused for the fixed-priority build with pointer tied to 0.

Test Plan:
1. Reset, then req0 writes addr 4 = 0xAA, req1 writes addr 7 = 0x55, both valid same cycle. Expected: req0 accepted first, req1 the next cycle; RAM holds 0xAA@4 and 0x55@7.
2. Both read continuously, addresses 4 and 7. Expected: grants alternate 0,1,0,1; rsp_valid[0] carries 0xAA and rsp_valid[1] carries 0x55, each one cycle after its accept.
3. req1 locks for 3 beats writing 0x33@2, 0x11@3, 0x22@5 while req0 is valid. Expected: req0 ready stays 0 for 3 cycles, busy = 1; req0 accepted on the next cycle.
4. Locked requester drops valid for 2 cycles. Expected: no acceptance, ram_we = 0, state stays ST_LOCK.
5. Assert rst_n low the cycle after a read accept. Expected: rsp_valid = 0 immediately, busy = 0, next grant goes to req0.
6. Fixed-priority build, both always valid. Expected: req0 wins every cycle and req1 is never granted.

Source files
------------

// File: rtl/spram_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
// Build option SPRAM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package spram_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } arb_state_e;

   localparam int DEF_NUM_REQ = 2;
   localparam int DEF_ADDR_W  = 4;
   localparam int DEF_DATA_W  = 8;

   // Index width that stays legal for a single requester.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spram_arbiter_rr_pick.sv
// Combinational rotating picker: finds the first set request at or above start, wrapping.
// Yields one-hot grant, its index and an any-request flag.
module rr_pick
   import spram_arb_pkg::*;
#(
   parameter int N  = DEF_NUM_REQ,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   int p;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      p   = 0;
      for (int k = 0; k < N; k++) begin
         p = (int'(start) + k) % N;
         if (!any && req[p]) begin
            any    = 1'b1;
            gnt[p] = 1'b1;
            idx    = IW'(p);
         end
      end
   end

endmodule

// File: rtl/spram_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM, with grant lock for bursts.
// Define SPRAM_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration in the unlocked state.
module spram_arbiter
   import spram_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ-1:0]        req_lock,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      ram_we,
   output logic [ADDR_W-1:0]         ram_addr,
   output logic [DATA_W-1:0]         ram_din,
   input  logic [DATA_W-1:0]         ram_dout,
   output logic                      busy
);

   // Handshake: a beat moves on a rising edge where req_valid[i] && req_ready[i];
   // an unaccepted requester must hold its request stable until that edge.

   localparam int IDX_W = idx_w(NUM_REQ);

   arb_state_e         state;
   logic [IDX_W-1:0]   lock_id;
   logic [IDX_W-1:0]   start_ptr;
   logic [IDX_W-1:0]   pick_idx;
   logic [IDX_W-1:0]   gnt_idx;
   logic [NUM_REQ-1:0] pick_oh;
   logic               pick_any;
   logic               accept;
   logic               gnt_we;
   logic               gnt_lock;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  din_q;

`ifdef SPRAM_ARB_FIXED_PRIO_EN
   assign start_ptr = '0;
`else
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] nxt_ptr;

   // Leaving a beat unlocked (fresh or releasing a lock) hands priority to the next index.
   assign nxt_ptr   = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IDX_W'(1);
   assign start_ptr = rr_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (accept && !gnt_lock) begin
         rr_ptr <= nxt_ptr;
      end
   end
`endif

   rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
      .req   (req_valid),
      .start (start_ptr),
      .gnt   (pick_oh),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_comb begin
      req_ready = '0;
      if (state == ST_LOCK) begin
         gnt_idx            = lock_id;
         accept             = req_valid[lock_id];
         req_ready[lock_id] = req_valid[lock_id];
      end else begin
         gnt_idx   = pick_idx;
         accept    = pick_any;
         req_ready = pick_oh;
      end
      gnt_we   = req_we[gnt_idx];
      gnt_lock = req_lock[gnt_idx];
      ram_we   = accept & gnt_we;
      ram_addr = accept ? req_addr[gnt_idx*ADDR_W +: ADDR_W] : addr_q;
      ram_din  = accept ? req_wdata[gnt_idx*DATA_W +: DATA_W] : din_q;
      rsp_data = (|rsp_valid) ? ram_dout : '0;
   end

   assign busy = (state == ST_LOCK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         lock_id   <= '0;
         rsp_valid <= '0;
         addr_q    <= '0;
         din_q     <= '0;
      end else begin
         rsp_valid <= '0;
         if (accept) begin
            addr_q <= ram_addr;
            din_q  <= ram_din;
            if (!gnt_we) rsp_valid <= req_ready;
            case (state)
               ST_IDLE: if (gnt_lock) begin
                  state   <= ST_LOCK;
                  lock_id <= gnt_idx;
               end
               ST_LOCK: if (!gnt_lock) state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
